// File: rtl/cpu_pkg.sv
// Shared types and width defaults for the execute/writeback datapath.
// Branch encodings match the 2-bit ex_br field driven by the execute stage.
package cpu_pkg;

    localparam int unsigned CPU_DATA_W = 32;
    localparam int unsigned CPU_REG_AW = 6;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_Z    = 2'd1,
        BR_N    = 2'd2,
        BR_JUMP = 2'd3
    } br_t;

    typedef enum logic {
        SQ_IDLE   = 1'b0,
        SQ_SQUASH = 1'b1
    } sq_state_t;

    // Control side of an ex_* beat; data fields travel alongside at module width.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic set_flags;
        br_t  br;
    } ex_beat_t;

endpackage

// File: rtl/flag_reg.sv
// Architectural Z/N flag register plus branch-taken decode.
// The decision always uses the stored flags, i.e. the value before any same-beat update.
module flag_reg
    import cpu_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic set_en_i,
    input  logic z_i,
    input  logic n_i,
    input  br_t  br_i,
    output logic z_o,
    output logic n_o,
    output logic taken_o
);

    logic z_q, n_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            z_q <= 1'b0;
            n_q <= 1'b0;
        end else if (set_en_i) begin
            z_q <= z_i;
            n_q <= n_i;
        end
    end

    always_comb begin
        taken_o = 1'b0;
        case (br_i)
            BR_Z:    taken_o = z_q;
            BR_N:    taken_o = n_q;
            BR_JUMP: taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end

    assign z_o = z_q;
    assign n_o = n_q;

endmodule

// File: rtl/wb_code.sv
// Writeback / branch-resolve stage: S1 capture, S2 memory-latency absorb, registered RF write,
// one-cycle PC redirect and squash of SHADOW valid beats after a taken branch or jump.
module wb_code
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_DATA_W,
    parameter int unsigned REG_AW = CPU_REG_AW,
    parameter int unsigned SHADOW = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              ex_valid,
    input  logic              ex_regWrite,
    input  logic              ex_memToReg,
    input  logic              ex_setFlags,
    input  logic [1:0]        ex_br,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              ex_zero,
    input  logic              ex_neg,
    input  logic [DATA_W-1:0] ex_target,
    input  logic [DATA_W-1:0] mem_readData,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_target,
    output logic              flush,
    output logic              flag_z,
    output logic              flag_n,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data
);

    localparam int unsigned SQ_W = (SHADOW < 1) ? 1 : $clog2(SHADOW + 1);

    ex_beat_t          beat;
    sq_state_t         state_q, state_d;
    logic [SQ_W-1:0]   sq_cnt_q, sq_cnt_d;
    logic              capture, br_taken, taken;

    logic              s1_valid_q, s1_we_q, s1_m2r_q;
    logic [REG_AW-1:0] s1_rd_q;
    logic [DATA_W-1:0] s1_res_q;
    logic              s2_we_q;
    logic [REG_AW-1:0] s2_rd_q;
    logic [DATA_W-1:0] s2_data_q;
    logic              rf_we_q, pc_load_q;
    logic [REG_AW-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q, pc_target_q;

    always_comb begin
        beat = '{reg_write:  ex_regWrite,
                 mem_to_reg: ex_memToReg,
                 set_flags:  ex_setFlags,
                 br:         br_t'(ex_br)};
    end

    assign capture = ex_valid && (state_q == SQ_IDLE);
    assign taken   = capture && br_taken;

    flag_reg u_flag_reg (
        .clk_i    (clock),
        .rst_ni   (reset_n),
        .set_en_i (capture && beat.set_flags),
        .z_i      (ex_zero),
        .n_i      (ex_neg),
        .br_i     (beat.br),
        .z_o      (flag_z),
        .n_o      (flag_n),
        .taken_o  (br_taken)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= SQ_IDLE;
            sq_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            sq_cnt_q <= sq_cnt_d;
        end
    end

    // Only valid beats consume shadow slots; idle cycles leave the count untouched.
    always_comb begin
        state_d  = state_q;
        sq_cnt_d = sq_cnt_q;
        case (state_q)
            SQ_IDLE: begin
                if (taken) begin
                    sq_cnt_d = SQ_W'(SHADOW);
                    state_d  = (SHADOW == 0) ? SQ_IDLE : SQ_SQUASH;
                end
            end
            SQ_SQUASH: begin
                if (ex_valid) begin
                    sq_cnt_d = sq_cnt_q - 1'b1;
                    if (sq_cnt_q == SQ_W'(1)) state_d = SQ_IDLE;
                end
            end
            default: state_d = SQ_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_we_q     <= 1'b0;
            s1_m2r_q    <= 1'b0;
            s1_rd_q     <= '0;
            s1_res_q    <= '0;
            s2_we_q     <= 1'b0;
            s2_rd_q     <= '0;
            s2_data_q   <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            pc_load_q   <= 1'b0;
            pc_target_q <= '0;
        end else begin
            s1_valid_q  <= capture;
            s1_we_q     <= beat.reg_write;
            s1_m2r_q    <= beat.mem_to_reg;
            s1_rd_q     <= ex_rd;
            s1_res_q    <= ex_result;
            s2_we_q     <= s1_valid_q && s1_we_q;
            s2_rd_q     <= s1_rd_q;
            s2_data_q   <= s1_m2r_q ? mem_readData : s1_res_q;
            rf_we_q     <= s2_we_q;
            rf_waddr_q  <= s2_rd_q;
            rf_wdata_q  <= s2_data_q;
            pc_load_q   <= taken;
            if (taken) pc_target_q <= ex_target;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;
    assign pc_load   = pc_load_q;
    assign pc_target = pc_target_q;
    assign flush     = (state_q == SQ_SQUASH);
    assign fwd_valid = s1_valid_q && s1_we_q && !s1_m2r_q;
    assign fwd_rd    = s1_rd_q;
    assign fwd_data  = s1_res_q;

endmodule

// File: tb/tb_wb_code.sv
// Scoreboard bench for wb_code: a beat-level reference model pushes expected RF writes and
// redirects when a beat is driven; a negedge monitor pops and compares them as the DUT emits.
module tb_wb_code;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 6;
    localparam int unsigned SH = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          ex_valid = 1'b0, ex_regWrite = 1'b0, ex_memToReg = 1'b0, ex_setFlags = 1'b0;
    logic [1:0]    ex_br = 2'd0;
    logic [AW-1:0] ex_rd = '0;
    logic [DW-1:0] ex_result = '0, ex_target = '0, mem_readData = '0;
    logic          ex_zero = 1'b0, ex_neg = 1'b0;
    logic          rf_we, pc_load, flush, flag_z, flag_n, fwd_valid;
    logic [AW-1:0] rf_waddr, fwd_rd;
    logic [DW-1:0] rf_wdata, pc_target, fwd_data;

    wb_code #(.DATA_W(DW), .REG_AW(AW), .SHADOW(SH)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ex_valid     (ex_valid),
        .ex_regWrite  (ex_regWrite),
        .ex_memToReg  (ex_memToReg),
        .ex_setFlags  (ex_setFlags),
        .ex_br        (ex_br),
        .ex_rd        (ex_rd),
        .ex_result    (ex_result),
        .ex_zero      (ex_zero),
        .ex_neg       (ex_neg),
        .ex_target    (ex_target),
        .mem_readData (mem_readData),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .pc_load      (pc_load),
        .pc_target    (pc_target),
        .flush        (flush),
        .flag_z       (flag_z),
        .flag_n       (flag_n),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data)
    );

    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [AW+DW-1:0] wr_q[$];
    logic [DW-1:0]    pc_q[$];
    logic             m_z = 1'b0, m_n = 1'b0;
    int unsigned      m_sq = 0;
    logic [DW-1:0]    pend_mem = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            if (rf_we) begin
                if (wr_q.size() == 0) check("rf_unexp", 64'(rf_we), 64'd0);
                else check("rf_write", 64'({rf_waddr, rf_wdata}), 64'(wr_q.pop_front()));
            end
            if (pc_load) begin
                if (pc_q.size() == 0) check("pc_unexp", 64'(pc_load), 64'd0);
                else check("pc_target", 64'(pc_target), 64'(pc_q.pop_front()));
            end
        end
    end

    // Drive one cycle; mem is the load data this beat sees one cycle later.
    task automatic drive(input bit v, input bit rw, input bit m2r, input bit sf,
                         input logic [1:0] br, input logic [AW-1:0] rd,
                         input logic [DW-1:0] res, input bit z, input bit n,
                         input logic [DW-1:0] tgt, input logic [DW-1:0] mem);
        bit cap, tk;
        mem_readData = pend_mem;
        pend_mem     = mem;
        ex_valid = v; ex_regWrite = rw; ex_memToReg = m2r; ex_setFlags = sf;
        ex_br = br; ex_rd = rd; ex_result = res; ex_zero = z; ex_neg = n; ex_target = tgt;
        cap = v && (m_sq == 0);
        if (v && m_sq > 0) m_sq--;
        if (cap) begin
            if (rw) wr_q.push_back({rd, m2r ? mem : res});
            tk = (br == 2'd3) || (br == 2'd1 && m_z) || (br == 2'd2 && m_n);
            if (tk) begin
                pc_q.push_back(tgt);
                m_sq = SH;
            end
            if (sf) begin
                m_z = z;
                m_n = n;
            end
        end
        @(posedge clock);
        #1;
        check("fwd_valid", 64'(fwd_valid), 64'(cap && rw && !m2r));
        if (cap && rw && !m2r) check("fwd_rd_data", 64'({fwd_rd, fwd_data}), 64'({rd, res}));
        check("flush", 64'(flush), 64'(m_sq > 0));
        check("flags", 64'({flag_z, flag_n}), 64'({m_z, m_n}));
    endtask

    task automatic idle(input int unsigned cycles);
        for (int unsigned i = 0; i < cycles; i++)
            drive(0, 0, 0, 0, 2'd0, '0, '0, 0, 0, '0, $urandom());
    endtask

    task automatic alu(input logic [AW-1:0] rd, input logic [DW-1:0] res);
        drive(1, 1, 0, 0, 2'd0, rd, res, 0, 0, '0, $urandom());
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_ctrl", 64'({rf_we, pc_load, flush, flag_z, flag_n, fwd_valid}), 64'd0);
        check("rst_data", 64'(rf_wdata | pc_target | fwd_data), 64'd0);
        check("rst_addr", 64'({rf_waddr, fwd_rd}), 64'd0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        alu(6'd5, 32'h2A);
        drive(1, 1, 1, 0, 2'd0, 6'd3, 32'hDEAD, 0, 0, '0, 32'h13);
        for (int i = 0; i < 4; i++)
            drive(1, 1, 1, 0, 2'd0, 6'(i + 8), $urandom(), 0, 0, '0, $urandom());
        alu(6'd0, 32'h0000_0777);
        idle(3);

        // flag branch with regular shadow
        drive(1, 1, 0, 1, 2'd0, 6'd7, 32'h0, 1, 0, '0, '0);
        drive(1, 0, 0, 0, 2'd1, 6'd0, 32'h0, 0, 0, 32'h40, '0);
        alu(6'd10, 32'hA);
        alu(6'd11, 32'hB);
        alu(6'd12, 32'hC);
        idle(3);

        // same-beat set+branch uses the old (cleared) flags
        drive(1, 0, 0, 1, 2'd0, '0, '0, 0, 0, '0, '0);
        drive(1, 0, 0, 1, 2'd1, '0, '0, 1, 0, 32'h80, '0);
        drive(1, 0, 0, 1, 2'd2, '0, '0, 0, 1, 32'h90, '0);
        drive(1, 1, 0, 0, 2'd2, 6'd1, 32'h5, 0, 0, 32'hA0, '0);
        idle(2);

        // shadow across idle cycles, with a jump in the shadow ignored
        drive(1, 0, 0, 0, 2'd3, '0, '0, 0, 0, 32'h100, '0);
        idle(3);
        drive(1, 1, 0, 0, 2'd3, 6'd20, 32'h20, 0, 0, 32'h200, '0);
        idle(2);
        alu(6'd21, 32'h21);
        alu(6'd22, 32'h22);
        idle(3);

        for (int i = 0; i < 40; i++)
            drive($urandom_range(0, 3) != 0, 1'($urandom()), 1'($urandom()), 1'($urandom()),
                  2'($urandom()), 6'($urandom()), $urandom(), 1'($urandom()), 1'($urandom()),
                  $urandom(), $urandom());
        idle(4 + SH);
        check("drain_wr", 64'(wr_q.size()), 64'd0);
        check("drain_pc", 64'(pc_q.size()), 64'd0);

        // reset mid-flight: load+jump beat in S1, squash pending
        alu(6'd30, 32'h30);
        drive(1, 1, 1, 1, 2'd3, 6'd31, 32'h0, 1, 1, 32'h300, 32'h55);
        reset_n = 1'b0;
        #1;
        check("rst_mid_ctrl", 64'({rf_we, pc_load, flush, flag_z, flag_n, fwd_valid}), 64'd0);
        wr_q.delete();
        pc_q.delete();
        m_z = 1'b0; m_n = 1'b0; m_sq = 0; pend_mem = '0;
        #1;
        reset_n = 1'b1;
        idle(4);
        alu(6'd40, 32'h40);
        idle(4);
        check("final_wr", 64'(wr_q.size()), 64'd0);
        check("final_pc", 64'(pc_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
